multi_digit_counter_7seg: RTL and testbench

- Parametrised successor to the single-digit counter/7-segment block in tt_um_conta.
- N-digit BCD or hex counter driven by a prescaled tick. Supports up/down counting, synchronous load, and wrap or saturate mode.
- Drives one shared 7-segment bus through time-multiplexed one-hot digit enables.
- Sits between the TinyTapeout top wrapper (ui_in/uo_out/uio mapping) and the board display.

---
 rtl/multi_digit_counter_7seg.sv | 187 ++++++++++++++++++
 tb/tb_multi_digit_counter_7seg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_counter_7seg.sv
// N-digit BCD/hex up/down counter with prescaled tick, load, wrap/saturate,
// and a time-multiplexed 7-segment driver with one-hot digit enables.
module multi_digit_counter_7seg #(
   parameter int DIGITS         = 2,
   parameter int PRESCALE       = 1000,
   parameter int MUX_DIV        = 16,
   parameter int DECIMAL        = 1,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  sat_mode,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tick,
   output logic                  wrap,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [3:0]        DMAX    = (DECIMAL != 0) ? 4'd9 : 4'd15;
   localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] DIG_INV = (SEG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0:    seg_decode = 7'h3F;
         4'h1:    seg_decode = 7'h06;
         4'h2:    seg_decode = 7'h5B;
         4'h3:    seg_decode = 7'h4F;
         4'h4:    seg_decode = 7'h66;
         4'h5:    seg_decode = 7'h6D;
         4'h6:    seg_decode = 7'h7D;
         4'h7:    seg_decode = 7'h07;
         4'h8:    seg_decode = 7'h7F;
         4'h9:    seg_decode = 7'h6F;
         4'hA:    seg_decode = 7'h77;
         4'hB:    seg_decode = 7'h7C;
         4'hC:    seg_decode = 7'h39;
         4'hD:    seg_decode = 7'h5E;
         4'hE:    seg_decode = 7'h79;
         4'hF:    seg_decode = 7'h71;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   // In BCD mode an out-of-range load digit saturates to 9 so the counter never holds A-F.
   function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if ((DECIMAL != 0) && (v[4*i +: 4] > 4'd9)) begin
            r[4*i +: 4] = 4'd9;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   logic [PW-1:0]     psc_r;
   logic [MW-1:0]     mux_r;
   logic [IW-1:0]     idx_r;
   logic [W-1:0]      count_r;
   logic              tick_r;
   logic              wrap_r;
   logic [6:0]        seg_r;
   logic [DIGITS-1:0] dig_sel_r;

   logic              tick_s;
   logic              carry_s;
   logic [W-1:0]      step_s;
   logic [W-1:0]      next_count_s;
   logic              next_wrap_s;
   logic [3:0]        digit_s;
   logic [DIGITS-1:0] onehot_s;

   assign tick_s   = en && (psc_r == PW'(PRESCALE - 1));
   assign digit_s  = count_r[{idx_r, 2'b00} +: 4];
   assign onehot_s = DIGITS'(1) << idx_r;

   // Ripple increment/decrement; a carry out of the top digit marks a bound crossing.
   always_comb begin
      step_s  = count_r;
      carry_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry_s) begin
            if (up) begin
               if (count_r[4*i +: 4] == DMAX) begin
                  step_s[4*i +: 4] = 4'd0;
               end else begin
                  step_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
                  carry_s          = 1'b0;
               end
            end else begin
               if (count_r[4*i +: 4] == 4'd0) begin
                  step_s[4*i +: 4] = DMAX;
               end else begin
                  step_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
                  carry_s          = 1'b0;
               end
            end
         end else begin
            step_s[4*i +: 4] = count_r[4*i +: 4];
         end
      end
   end

   // Saturate holds the value at the bound; otherwise take the wrapped ripple result.
   always_comb begin
      next_count_s = step_s;
      next_wrap_s  = 1'b0;
      if (carry_s && sat_mode) begin
         next_count_s = count_r;
         next_wrap_s  = 1'b0;
      end else if (carry_s) begin
         next_count_s = step_s;
         next_wrap_s  = 1'b1;
      end else begin
         next_count_s = step_s;
         next_wrap_s  = 1'b0;
      end
   end

   // Prescaler and counter state; load outranks the tick and restarts the prescaler.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_r   <= '0;
         count_r <= '0;
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else if (load) begin
         psc_r   <= '0;
         count_r <= clamp_load(load_val);
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else if (tick_s) begin
         psc_r   <= '0;
         count_r <= next_count_s;
         tick_r  <= 1'b1;
         wrap_r  <= next_wrap_s;
      end else begin
         if (en) begin
            psc_r <= psc_r + PW'(1);
         end
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
      end
   end

   // Free-running display scan; seg and dig_sel are registered from the current index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mux_r     <= '0;
         idx_r     <= '0;
         seg_r     <= 7'h3F ^ SEG_INV;
         dig_sel_r <= DIGITS'(1) ^ DIG_INV;
      end else begin
         if (mux_r == MW'(MUX_DIV - 1)) begin
            mux_r <= '0;
            if (idx_r == IW'(DIGITS - 1)) begin
               idx_r <= '0;
            end else begin
               idx_r <= idx_r + IW'(1);
            end
         end else begin
            mux_r <= mux_r + MW'(1);
         end
         seg_r     <= seg_decode(digit_s) ^ SEG_INV;
         dig_sel_r <= onehot_s ^ DIG_INV;
      end
   end

   assign count   = count_r;
   assign tick    = tick_r;
   assign wrap    = wrap_r;
   assign seg     = seg_r;
   assign dig_sel = dig_sel_r;

endmodule

// File: tb/tb_multi_digit_counter_7seg.sv
// Directed bench: default BCD instance plus active-low and hex instances on shared stimulus.
module tb_multi_digit_counter_7seg;

   logic       clk = 1'b0;
   logic       rst, en, up, sat_mode, load;
   logic [7:0] load_val;

   logic [7:0] count, count_al, count_hx;
   logic       tick, tick_al, tick_hx;
   logic       wrap, wrap_al, wrap_hx;
   logic [6:0] seg, seg_al, seg_hx;
   logic [1:0] dig_sel, dig_sel_al, dig_sel_hx;

   int errors = 0;
   int checks = 0;

   multi_digit_counter_7seg #(.DIGITS(2), .PRESCALE(4), .MUX_DIV(2), .DECIMAL(1), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load), .load_val(load_val),
      .count(count), .tick(tick), .wrap(wrap), .seg(seg), .dig_sel(dig_sel));

   multi_digit_counter_7seg #(.DIGITS(2), .PRESCALE(4), .MUX_DIV(2), .DECIMAL(1), .SEG_ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load), .load_val(load_val),
      .count(count_al), .tick(tick_al), .wrap(wrap_al), .seg(seg_al), .dig_sel(dig_sel_al));

   multi_digit_counter_7seg #(.DIGITS(2), .PRESCALE(4), .MUX_DIV(2), .DECIMAL(0), .SEG_ACTIVE_LOW(0)) dut_hx (
      .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load), .load_val(load_val),
      .count(count_hx), .tick(tick_hx), .wrap(wrap_hx), .seg(seg_hx), .dig_sel(dig_sel_hx));

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int n);
      return {4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load     = 1'b1;
      load_val = v;
      step();
      load     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0; load_val = 8'h00;
      step();
      checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h expected 00", count); end
      checks++; if ({tick, wrap} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {tick, wrap}); end
      checks++; if ({dig_sel, seg} !== {2'b01, 7'h3F}) begin errors++; $display("FAIL reset_display: got %b/%h expected 01/3f", dig_sel, seg); end
      checks++; if ({dig_sel_al, seg_al} !== {2'b10, 7'h40}) begin errors++; $display("FAIL reset_display_al: got %b/%h expected 10/40", dig_sel_al, seg_al); end
      rst = 1'b0;
      step();
      en = 1'b1;
      repeat (6) step();
      checks++; if (count !== 8'h01) begin errors++; $display("FAIL pre_reset_count: got %h expected 01", count); end
      rst = 1'b1;
      #2;
      checks++; if ({count, tick, dig_sel, seg} !== {8'h00, 1'b0, 2'b01, 7'h3F})
         begin errors++; $display("FAIL async_reset: got %h/%b/%b/%h expected 00/0/01/3f", count, tick, dig_sel, seg); end
      step();
      rst = 1'b0; en = 1'b0;
      step();
   endtask

   task automatic test_up_count();
      up = 1'b1; sat_mode = 1'b0; en = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         checks++; if (tick !== ((c % 4) == 0)) begin errors++; $display("FAIL up_tick c=%0d: got %b expected %b", c, tick, (c % 4) == 0); end
         checks++; if (count !== bcd(c / 4)) begin errors++; $display("FAIL up_count c=%0d: got %h expected %h", c, count, bcd(c / 4)); end
      end
      checks++; if (count !== 8'h10) begin errors++; $display("FAIL up_carry: got %h expected 10", count); end
      en = 1'b0;
   endtask

   task automatic test_wrap();
      up = 1'b1; sat_mode = 1'b0;
      do_load(8'h99);
      en = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++; if ({count, wrap, tick} !== ((c == 4) ? {8'h00, 2'b11} : {8'h99, 2'b00}))
            begin errors++; $display("FAIL wrap_up c=%0d: got %h/%b/%b", c, count, wrap, tick); end
      end
      en = 1'b0;
      step();
      checks++; if ({count, wrap} !== {8'h00, 1'b0}) begin errors++; $display("FAIL wrap_one_cycle: got %h/%b expected 00/0", count, wrap); end
      sat_mode = 1'b1;
      do_load(8'h99);
      en = 1'b1;
      repeat (4) step();
      checks++; if ({count, wrap, tick} !== {8'h99, 2'b01}) begin errors++; $display("FAIL sat_up: got %h/%b/%b expected 99/0/1", count, wrap, tick); end
      en = 1'b0; sat_mode = 1'b0;
   endtask

   task automatic test_down();
      up = 1'b0; sat_mode = 1'b0;
      do_load(8'h10);
      en = 1'b1;
      repeat (4) step();
      checks++; if ({count, tick, wrap} !== {8'h09, 2'b10}) begin errors++; $display("FAIL down_borrow: got %h/%b/%b expected 09/1/0", count, tick, wrap); end
      en = 1'b0;
      do_load(8'h00);
      en = 1'b1;
      repeat (4) step();
      checks++; if ({count, wrap} !== {8'h99, 1'b1}) begin errors++; $display("FAIL down_wrap: got %h/%b expected 99/1", count, wrap); end
      en = 1'b0; sat_mode = 1'b1;
      do_load(8'h00);
      en = 1'b1;
      repeat (4) step();
      checks++; if ({count, wrap, tick} !== {8'h00, 2'b01}) begin errors++; $display("FAIL down_sat: got %h/%b/%b expected 00/0/1", count, wrap, tick); end
      en = 1'b0; sat_mode = 1'b0; up = 1'b1;
   endtask

   task automatic test_load();
      up = 1'b1; en = 1'b0;
      do_load(8'h3C);
      checks++; if (count !== 8'h39) begin errors++; $display("FAIL load_clamp: got %h expected 39", count); end
      do_load(8'hA7);
      checks++; if (count !== 8'h97) begin errors++; $display("FAIL load_clamp_hi: got %h expected 97", count); end
      do_load(8'h20);
      en = 1'b1;
      repeat (3) step();
      do_load(8'h25);
      checks++; if ({count, tick, wrap} !== {8'h25, 2'b00}) begin errors++; $display("FAIL load_beats_tick: got %h/%b/%b expected 25/0/0", count, tick, wrap); end
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++; if ({count, tick} !== ((c == 4) ? {8'h26, 1'b1} : {8'h25, 1'b0}))
            begin errors++; $display("FAIL load_restart c=%0d: got %h/%b", c, count, tick); end
      end
      en = 1'b0;
      do_load(8'h55);
      for (int c = 1; c <= 12; c++) begin
         step();
         checks++; if ({count, tick} !== {8'h55, 1'b0}) begin errors++; $display("FAIL en_low_hold c=%0d: got %h/%b expected 55/0", c, count, tick); end
      end
      do_load(8'h30);
      en = 1'b1;
      repeat (3) step();
      en = 1'b0;
      step();
      checks++; if ({count, tick} !== {8'h30, 1'b0}) begin errors++; $display("FAIL en_cancel_tick: got %h/%b expected 30/0", count, tick); end
      en = 1'b1;
      step();
      checks++; if ({count, tick} !== {8'h31, 1'b1}) begin errors++; $display("FAIL en_resume: got %h/%b expected 31/1", count, tick); end
      en = 1'b0;
   endtask

   task automatic test_scan();
      logic [1:0] prev, cur, exp_dig;
      logic [6:0] exp_seg;
      logic       found;
      en = 1'b0;
      do_load(8'h47);
      step(); step();
      prev = dig_sel; found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         step();
         if (dig_sel !== prev) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL scan_toggle: got %b expected a change", dig_sel); end
      cur = dig_sel;
      checks++; if (cur !== 2'b01 && cur !== 2'b10) begin errors++; $display("FAIL scan_onehot: got %b expected 01 or 10", cur); end
      for (int k = 0; k < 8; k++) begin
         exp_dig = (((k / 2) % 2) == 0) ? cur : ~cur;
         exp_seg = (exp_dig == 2'b01) ? 7'h07 : 7'h66;
         checks++; if ({dig_sel, seg} !== {exp_dig, exp_seg}) begin errors++; $display("FAIL scan_47 k=%0d: got %b/%h expected %b/%h", k, dig_sel, seg, exp_dig, exp_seg); end
         checks++; if ({dig_sel_al, seg_al} !== {~exp_dig, ~exp_seg}) begin errors++; $display("FAIL scan_47_al k=%0d: got %b/%h expected %b/%h", k, dig_sel_al, seg_al, ~exp_dig, ~exp_seg); end
         step();
      end
      do_load(8'hAF);
      step(); step();
      checks++; if ({count_hx, count} !== {8'hAF, 8'h99}) begin errors++; $display("FAIL hex_load: got %h/%h expected af/99", count_hx, count); end
      for (int k = 0; k < 4; k++) begin
         exp_seg = (dig_sel_hx == 2'b01) ? 7'h71 : 7'h77;
         checks++; if (dig_sel_hx !== 2'b01 && dig_sel_hx !== 2'b10) begin errors++; $display("FAIL hex_onehot k=%0d: got %b", k, dig_sel_hx); end
         checks++; if (seg_hx !== exp_seg) begin errors++; $display("FAIL scan_af k=%0d: got %h expected %h", k, seg_hx, exp_seg); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_wrap();
      test_down();
      test_load();
      test_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
